// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data RAM with req/ready/rvalid handshake, wait states and B/H/W load/store.
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned/illegal accesses instead of masking them to natural alignment.
module data_memory_lsu #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int RAM_ADDRESS_WIDTH = 18,
    parameter int WAIT_CYCLES       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  fault_o
);
    localparam int DEPTH = 2 ** (RAM_ADDRESS_WIDTH - 2);
    localparam bit DIRECT = (WAIT_CYCLES == 0);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
`ifdef DMEM_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic [1:0]                   state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic                         we_q, rvalid_q, fault_q;
    logic [2:0]                   f3_q;
    logic [RAM_ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]        wdata_q, rdata_q;
    logic [DATA_WIDTH-1:0]        mem [DEPTH];

    logic                         accept, do_acc, a_we, illegal, misal, bad;
    logic [2:0]                   a_f3;
    logic [RAM_ADDRESS_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0]        a_wd, wlane, word, shifted, load_val;
    logic [1:0]                   size, lo;
    logic [3:0]                   be;
    logic                         unused_addr;

    assign unused_addr = ^addr_i[ADDR_WIDTH-1:RAM_ADDRESS_WIDTH];
    assign ready_o  = (state_q != WAIT);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign fault_o  = fault_q;
    assign accept   = req_i && ready_o;

    // Without wait states the access happens on the accept edge straight from the inputs.
    assign do_acc = DIRECT ? accept : (state_q == WAIT && cnt_q == 4'd0);
    assign a_we   = DIRECT ? we_i : we_q;
    assign a_f3   = DIRECT ? funct3_i : f3_q;
    assign a_addr = DIRECT ? addr_i[RAM_ADDRESS_WIDTH-1:0] : addr_q;
    assign a_wd   = DIRECT ? wdata_i : wdata_q;

    assign illegal  = (a_f3[1:0] == 2'b11) || (a_f3[2] && a_f3[1]) || (a_we && a_f3[2]);
    assign misal    = (a_f3[1:0] == 2'b01 && a_addr[0]) || (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
    assign bad      = FAULT_EN && (illegal || misal);
    assign size     = illegal ? 2'b10 : a_f3[1:0];
    assign lo       = size == 2'b10 ? 2'b00 : size == 2'b01 ? {a_addr[1], 1'b0} : a_addr[1:0];
    assign be       = size == 2'b10 ? 4'hF : size == 2'b01 ? (lo[1] ? 4'hC : 4'h3) : 4'b0001 << lo;
    assign wlane    = size == 2'b10 ? a_wd : size == 2'b01 ? {2{a_wd[15:0]}} : {4{a_wd[7:0]}};
    assign word     = mem[a_addr[RAM_ADDRESS_WIDTH-1:2]];
    assign shifted  = word >> {lo, 3'b000};
    assign load_val = size == 2'b10 ? word
                    : size == 2'b01 ? {{16{shifted[15] & ~a_f3[2]}}, shifted[15:0]}
                    : {{24{shifted[7] & ~a_f3[2]}}, shifted[7:0]};

    always_comb begin
        state_d = DIRECT ? (accept ? DONE : IDLE)
                : state_q == WAIT ? (cnt_q == 4'd0 ? DONE : WAIT)
                : accept ? WAIT : IDLE;
        cnt_d   = accept ? 4'(WAIT_CYCLES - 1) : cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_acc && a_we && !bad)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a_addr[RAM_ADDRESS_WIDTH-1:2]][8*i+:8] <= wlane[8*i+:8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= do_acc;
            fault_q  <= do_acc && bad;
            if (do_acc && !a_we) rdata_q <= bad ? '0 : load_val;
            if (accept) begin
                we_q    <= we_i;
                f3_q    <= funct3_i;
                addr_q  <= addr_i[RAM_ADDRESS_WIDTH-1:0];
                wdata_q <= wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: three instances (WAIT_CYCLES 0, 3, 2) checked every cycle against a byte-level model,
// plus literal expectations for the directed vectors; honours DMEM_MISALIGN_FAULT_EN.
module tb_data_memory_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, req, we, ready, rvalid, fault;
    logic [2:0]  f3 [3];
    logic [31:0] addr [3], wdata [3], rdata [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gd
            data_memory_lsu #(.WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)) dut (
                .clk(clk), .rst_n(rst_n[g]), .req_i(req[g]), .we_i(we[g]), .funct3_i(f3[g]),
                .addr_i(addr[g]), .wdata_i(wdata[g]), .ready_o(ready[g]), .rvalid_o(rvalid[g]),
                .rdata_o(rdata[g]), .fault_o(fault[g]));
        end
    endgenerate

    int          wt [3] = '{0, 3, 2};
    bit          mvalid = 0;
    bit          pv [3], pw [3], xrv [3], xf [3], xk [3], acc [3], rv_seen [3], last_f [3];
    int          left [3], rv_cnt [3];
    logic [2:0]  pf [3];
    logic [31:0] pa [3], pd [3], xr [3], last_r [3];
    logic [7:0]  mm [int];
    int          errors = 0, checks = 0;

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Byte-granular reference: addresses are plain integers, memory is a sparse byte map.
    task automatic perform(int k, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        bit ill, bad, known;
        int nb, base, key;
        logic [1:0] sz;
        logic [31:0] v;
        ill = (f[1:0] == 2'b11) || (f[2] && f[1]) || (w && f[2]);
        sz = f[1:0];
`ifdef DMEM_MISALIGN_FAULT_EN
        bad = ill || (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
        bad = 0;
        if (ill) sz = 2'b10;
`endif
        nb = 1 << sz;
        base = int'(a & 32'h3FFFF) & ~(nb - 1);
        xf[k] = bad;
        if (bad) begin
            if (!w) begin xr[k] = 0; xk[k] = 1; end
        end else if (w) begin
            for (int i = 0; i < nb; i++) mm[k * (1 << 20) + base + i] = d[8*i+:8];
        end else begin
            v = 0;
            known = 1;
            for (int i = 0; i < nb; i++) begin
                key = k * (1 << 20) + base + i;
                if (mm.exists(key)) v[8*i+:8] = mm[key];
                else known = 0;
            end
            if (!f[2] && nb == 1 && v[7]) v[31:8] = '1;
            if (!f[2] && nb == 2 && v[15]) v[31:16] = '1;
            xr[k] = v;
            xk[k] = known;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (mvalid) begin
                chk("ready", k, 32'(ready[k]), 32'(!pv[k]));
                chk("rvalid", k, 32'(rvalid[k]), 32'(xrv[k]));
                chk("fault", k, 32'(fault[k]), 32'(xrv[k] && xf[k]));
                if (xk[k]) chk("rdata", k, rdata[k], xr[k]);
            end
            if (rvalid[k] === 1'b1) begin
                rv_seen[k] = 1;
                rv_cnt[k]++;
                last_r[k] = rdata[k];
                last_f[k] = fault[k];
            end
            acc[k] = 0;
            if (rst_n[k] !== 1'b1) begin
                pv[k] = 0; xrv[k] = 0; xf[k] = 0; xr[k] = 0; xk[k] = 1;
            end else begin
                xrv[k] = 0;
                if (pv[k]) begin
                    if (left[k] == 0) begin
                        perform(k, pw[k], pf[k], pa[k], pd[k]);
                        pv[k] = 0;
                        xrv[k] = 1;
                    end else left[k]--;
                end else if (req[k]) begin
                    acc[k] = 1;
                    if (wt[k] == 0) begin
                        perform(k, we[k], f3[k], addr[k], wdata[k]);
                        xrv[k] = 1;
                    end else begin
                        pv[k] = 1; left[k] = wt[k] - 1;
                        pw[k] = we[k]; pf[k] = f3[k]; pa[k] = addr[k]; pd[k] = wdata[k];
                    end
                end
            end
        end
        if (rst_n == 3'b000) mvalid = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic op(int k, bit w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
        int n = 0;
        req[k] = 1; we[k] = w; f3[k] = f; addr[k] = a; wdata[k] = d;
        rv_seen[k] = 0;
        acc[k] = 0;
        while (!acc[k] && n < 30) begin tick(); n++; end
        req[k] = 0;
        while (!rv_seen[k] && n < 30) begin tick(); n++; end
        checks++;
        if (!rv_seen[k]) begin
            errors++;
            $display("FAIL timeout[%0d] no rvalid within 30 cycles for addr=%h", k, a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 3'b000; req = 3'b000; we = 3'b000;
        for (int k = 0; k < 3; k++) begin f3[k] = 0; addr[k] = 0; wdata[k] = 0; rv_cnt[k] = 0; end
        repeat (2) tick();
        rst_n = 3'b111;
        chk("rst_rdata", 0, rdata[0], 32'h0);
        chk("rst_ready", 1, 32'(ready[1]), 32'h1);
        tick();

        // back-to-back SW then LW with no wait states
        c0 = rv_cnt[0];
        req[0] = 1; we[0] = 1; f3[0] = 3'b010; addr[0] = 32'h100; wdata[0] = 32'hDEADBEEF;
        tick();
        we[0] = 0;
        tick();
        req[0] = 0;
        repeat (2) tick();
        chk("b2b_rvalids", 0, 32'(rv_cnt[0] - c0), 32'd2);
        chk("b2b_lw", 0, last_r[0], 32'hDEADBEEF);

        op(0, 1, 3'b000, 32'h102, 32'h00000055);
        op(0, 0, 3'b010, 32'h100, 0); chk("sb_merge", 0, last_r[0], 32'hDE55BEEF);
        op(0, 0, 3'b000, 32'h103, 0); chk("lb", 0, last_r[0], 32'hFFFFFFDE);
        op(0, 0, 3'b100, 32'h103, 0); chk("lbu", 0, last_r[0], 32'h000000DE);
        op(0, 0, 3'b001, 32'h102, 0); chk("lh", 0, last_r[0], 32'hFFFFDE55);
        op(0, 0, 3'b101, 32'h100, 0); chk("lhu", 0, last_r[0], 32'h0000BEEF);
        op(0, 1, 3'b010, 32'h0004_0010, 32'h12345678);
        op(0, 0, 3'b010, 32'h0000_0010, 0); chk("alias", 0, last_r[0], 32'h12345678);
`ifdef DMEM_MISALIGN_FAULT_EN
        op(0, 1, 3'b010, 32'h101, 32'h11111111); chk("sw_mis_fault", 0, 32'(last_f[0]), 1);
        op(0, 0, 3'b010, 32'h100, 0); chk("sw_mis_nowrite", 0, last_r[0], 32'hDE55BEEF);
        op(0, 0, 3'b001, 32'h101, 0); chk("lh_mis_rdata", 0, last_r[0], 0);
        chk("lh_mis_fault", 0, 32'(last_f[0]), 1);
        op(0, 0, 3'b011, 32'h100, 0); chk("illegal_fault", 0, 32'(last_f[0]), 1);
`else
        op(0, 0, 3'b010, 32'h103, 0); chk("lw_masked", 0, last_r[0], 32'hDE55BEEF);
        chk("lw_masked_fault", 0, 32'(last_f[0]), 0);
        op(0, 0, 3'b011, 32'h100, 0); chk("illegal_as_w", 0, last_r[0], 32'hDE55BEEF);
`endif

        // WAIT_CYCLES=3: request held through the stall must not be accepted again
        op(1, 1, 3'b010, 32'h100, 32'hCAFEF00D);
        c0 = rv_cnt[1];
        req[1] = 1; we[1] = 0; f3[1] = 3'b010; addr[1] = 32'h100;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait_ready_low", 1, 32'(ready[1]), 0);
            tick();
        end
        req[1] = 0;
        chk("wait_ready_back", 1, 32'(ready[1]), 1);
        chk("wait_rvalid", 1, 32'(rvalid[1]), 1);
        repeat (3) tick();
        chk("wait_one_rvalid", 1, 32'(rv_cnt[1] - c0), 1);
        chk("wait_lw", 1, last_r[1], 32'hCAFEF00D);
        op(1, 1, 3'b001, 32'h102, 32'h0000A5A5);
        op(1, 0, 3'b010, 32'h100, 0); chk("wait_sh", 1, last_r[1], 32'hA5A5F00D);

        // WAIT_CYCLES=2: reset right after accept drops the store
        rv_seen[2] = 0;
        req[2] = 1; we[2] = 1; f3[2] = 3'b010; addr[2] = 32'h200; wdata[2] = 32'hAAAAAAAA;
        tick();
        req[2] = 0;
        rst_n[2] = 0;
        tick();
        rst_n[2] = 1;
        repeat (4) tick();
        chk("rst_no_rvalid", 2, 32'(rv_seen[2]), 0);
        op(2, 0, 3'b010, 32'h200, 0);
        checks++;
        if (last_r[2] === 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL rst_dropped_store[2] got=%h expected anything but aaaaaaaa", last_r[2]);
        end
        op(2, 1, 3'b010, 32'h200, 32'h13579BDF);
        op(2, 0, 3'b000, 32'h201, 0); chk("w2_lb", 2, last_r[2], 32'hFFFFFF9B);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
